cache_mem_arbiter: RTL and testbench

- Shares the single physical-memory line port between the I-cache (fetch stage) and the D-cache (MEM stage) of the pipelined LC-3b core.
- Each cache issues whole-line misses and writebacks through it.
- Arbitration is round-robin when both caches contend. A transaction is never pre-empted.
- Sits between the two cache controllers and the memory model or L2.

---
 rtl/cache_mem_arbiter.sv | 87 ++++++++
 tb/tb_cache_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one memory line port between I-cache and D-cache; perf counters built when CACHE_ARB_PERF_EN is defined
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [15:0]           perf_i_grants,
  output logic [15:0]           perf_d_grants,
  output logic [15:0]           perf_conflicts
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t                state;
  logic                  last_grant;
  logic                  is_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  i_req, d_req, grant, grant_d;
  assign i_req   = icache_read;
  assign d_req   = dcache_read | dcache_write;
  assign grant   = (state == IDLE) && (i_req || d_req);
  assign grant_d = d_req && (!i_req || !last_grant);
  // Arbitrate in IDLE, latch the winner's request, hold it until memory completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (state == IDLE) begin
      if (grant) begin
        state      <= grant_d ? SERVE_D : SERVE_I;
        last_grant <= grant_d;
        is_write_q <= grant_d && dcache_write;
        addr_q     <= grant_d ? dcache_address : icache_address;
        wdata_q    <= grant_d ? dcache_wdata : '0;
      end
    end else if (pmem_resp) begin
      state <= IDLE;
    end
  end
  assign pmem_read    = (state != IDLE) && !is_write_q;
  assign pmem_write   = (state != IDLE) && is_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign icache_resp  = (state == SERVE_I) && pmem_resp;
  assign dcache_resp  = (state == SERVE_D) && pmem_resp;
  assign icache_rdata = icache_resp ? pmem_rdata : '0;
  assign dcache_rdata = dcache_resp ? pmem_rdata : '0;
`ifdef CACHE_ARB_PERF_EN
  logic conflict;
  assign conflict = (state == IDLE) && i_req && d_req;
  // Saturating grant and contention counters, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant && !grant_d && perf_i_grants != 16'hFFFF) perf_i_grants <= perf_i_grants + 16'd1;
      if (grant && grant_d && perf_d_grants != 16'hFFFF) perf_d_grants <= perf_d_grants + 16'd1;
      if (conflict && perf_conflicts != 16'hFFFF) perf_conflicts <= perf_conflicts + 16'd1;
    end
  end
`else
  assign perf_i_grants  = '0;
  assign perf_d_grants  = '0;
  assign perf_conflicts = '0;
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of arbitration order, data hold, async reset and perf counters
module tb_cache_mem_arbiter;
`ifdef CACHE_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         reset_n;
  logic         icache_read, dcache_read, dcache_write;
  logic [15:0]  icache_address, dcache_address;
  logic [127:0] icache_rdata, dcache_rdata, dcache_wdata;
  logic         icache_resp, dcache_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata, rdata_val;
  logic [15:0]  perf_i_grants, perf_d_grants, perf_conflicts;
  logic [3:0]   mcnt;
  int           checks = 0;
  int           errors = 0;
  int           side;
  logic [15:0]  addr;
  logic [127:0] data;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] W1 = {4{32'h1111_2222}};
  localparam logic [127:0] W2 = {4{32'h3333_4444}};
  localparam logic [127:0] RD = {4{32'hCAFE_0123}};

  cache_mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  // memory model: completion strobe 3 cycles after a request is first seen
  assign pmem_rdata = rdata_val;
  always @(posedge clk) begin
    if (!reset_n || pmem_resp || !(pmem_read || pmem_write)) begin
      mcnt      <= '0;
      pmem_resp <= 1'b0;
    end else begin
      mcnt      <= mcnt + 4'd1;
      pmem_resp <= (mcnt == 4'd2);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0;
    step;
    step;
    reset_n = 1'b1;
  endtask

  task automatic run_txn(input bit drop, output int s, output logic [15:0] a, output logic [127:0] d);
    s = -1; a = '0; d = '0;
    for (int n = 0; n < 20 && s < 0; n++) begin
      step;
      if (icache_resp) begin
        s = 0; a = pmem_address; d = icache_rdata;
        if (drop) icache_read = 1'b0;
      end else if (dcache_resp) begin
        s = 1; a = pmem_address; d = dcache_rdata;
        if (drop) begin dcache_read = 1'b0; dcache_write = 1'b0; end
      end
    end
    chk("txn_done", 128'(s >= 0), 128'(1));
  endtask

  initial begin
    rdata_val = A5;
    do_reset;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_iresp", icache_resp, 0);
    chk("rst_perf", {perf_i_grants, perf_d_grants, perf_conflicts}, 0);
    // single I-cache fetch
    icache_read = 1'b1; icache_address = 16'h1230;
    step;
    chk("s1_read", pmem_read, 1);
    chk("s1_addr", pmem_address, 16'h1230);
    step; step;
    chk("s1_resp_early", icache_resp, 0);
    chk("s1_rdata_idle", icache_rdata, 0);
    step;
    chk("s1_resp", icache_resp, 1);
    chk("s1_rdata", icache_rdata, A5);
    chk("s1_dresp", dcache_resp, 0);
    icache_read = 1'b0;
    step;
    chk("s1_resp_once", icache_resp, 0);
    chk("s1_read_idle", pmem_read, 0);
    // simultaneous first requests: D wins, I follows after one IDLE cycle
    do_reset;
    rdata_val = RD;
    icache_read = 1'b1; icache_address = 16'h0040;
    dcache_read = 1'b1; dcache_address = 16'h0080;
    step;
    chk("s2_first_addr", pmem_address, 16'h0080);
    run_txn(1'b1, side, addr, data);
    chk("s2_first_side", side, 1);
    chk("s2_drdata", data, RD);
    step;
    chk("s2_idle", pmem_read, 0);
    step;
    chk("s2_second_read", pmem_read, 1);
    chk("s2_second_addr", pmem_address, 16'h0040);
    run_txn(1'b1, side, addr, data);
    chk("s2_second_side", side, 0);
    // continuous contention for 10 transactions
    do_reset;
    icache_read = 1'b1; icache_address = 16'h1110;
    dcache_read = 1'b1; dcache_address = 16'h2220;
    for (int k = 0; k < 10; k++) begin
      run_txn(1'b0, side, addr, data);
      chk($sformatf("s3_side%0d", k), side, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("s3_addr%0d", k), addr, (k % 2 == 0) ? 16'h2220 : 16'h1110);
      if (k == 5) begin
        chk("s3_conf6", perf_conflicts, PERF ? 6 : 0);
        chk("s3_igr6", perf_i_grants, PERF ? 3 : 0);
        chk("s3_dgr6", perf_d_grants, PERF ? 3 : 0);
      end
    end
    chk("s6_conf10", perf_conflicts, PERF ? 10 : 0);
    chk("s6_igr10", perf_i_grants, PERF ? 5 : 0);
    chk("s6_dgr10", perf_d_grants, PERF ? 5 : 0);
    icache_read = 1'b0; dcache_read = 1'b0;
    step;
    // writeback data is latched at grant
    do_reset;
    dcache_write = 1'b1; dcache_address = 16'hBEE0; dcache_wdata = W1;
    step;
    dcache_wdata = W2; dcache_address = 16'h0000;
    side = -1;
    for (int n = 0; n < 10 && side < 0; n++) begin
      chk($sformatf("s4_write%0d", n), pmem_write, 1);
      chk($sformatf("s4_read%0d", n), pmem_read, 0);
      chk($sformatf("s4_wdata%0d", n), pmem_wdata, W1);
      chk($sformatf("s4_addr%0d", n), pmem_address, 16'hBEE0);
      if (dcache_resp) side = 1;
      else step;
    end
    chk("s4_done", side, 1);
    dcache_write = 1'b0;
    step;
    // read and write together is served as a write
    dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h5550;
    step;
    chk("s4_rw_write", pmem_write, 1);
    chk("s4_rw_read", pmem_read, 0);
    run_txn(1'b1, side, addr, data);
    chk("s4_rw_side", side, 1);
    // async reset during an I-cache completion
    do_reset;
    icache_read = 1'b1; icache_address = 16'h3330;
    step;
    chk("s5_read", pmem_read, 1);
    step; step; step;
    chk("s5_resp_before", icache_resp, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_async_read", pmem_read, 0);
    chk("s5_async_resp", icache_resp, 0);
    chk("s5_async_rdata", icache_rdata, 0);
    step;
    reset_n = 1'b1;
    step;
    chk("s5_regrant", pmem_read, 1);
    chk("s5_regrant_addr", pmem_address, 16'h3330);
    run_txn(1'b1, side, addr, data);
    chk("s5_side", side, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
